// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional same-cycle write-to-read bypass.
// A clear sequencer zeroes every entry after reset; ready is high once that sweep is done.
module regfile_mp #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_SEL_BITS   = 5,
    parameter int NUM_READ       = 2,
    parameter int NUM_WRITE      = 2,
    parameter int BYPASS         = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    output logic                                 ready,
    input  logic [NUM_WRITE-1:0]                 wEn,
    input  logic [NUM_WRITE*REG_SEL_BITS-1:0]    write_sel,
    input  logic [NUM_WRITE*REG_DATA_WIDTH-1:0]  write_data,
    input  logic [NUM_READ*REG_SEL_BITS-1:0]     read_sel,
    output logic [NUM_READ*REG_DATA_WIDTH-1:0]   read_data
);

    localparam int DEPTH = 1 << REG_SEL_BITS;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [REG_SEL_BITS-1:0]   cnt_q, cnt_d;
    logic                      ready_q, ready_d;
    logic [REG_DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [REG_DATA_WIDTH-1:0] regs_d [DEPTH];

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        if (state_q == CLEAR) begin
            regs_d[cnt_q] = '0;
            // The counter parks on the last entry instead of wrapping back to zero.
            if (cnt_q == {REG_SEL_BITS{1'b1}}) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            // Ascending port order lets the higher port win an address conflict.
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wEn[w] && (write_sel[w*REG_SEL_BITS +: REG_SEL_BITS] != '0)) begin
                    regs_d[write_sel[w*REG_SEL_BITS +: REG_SEL_BITS]] =
                        write_data[w*REG_DATA_WIDTH +: REG_DATA_WIDTH];
                end
            end
        end
        ready_d = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // NOTE: the array has no reset branch; the clear sequencer zeroes it, and a write
    // presented on a reset edge is simply not captured.
    always_ff @(posedge clock) begin
        if (!reset) begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        read_data = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            if ((state_q == RUN) && (read_sel[r*REG_SEL_BITS +: REG_SEL_BITS] != '0)) begin
                read_data[r*REG_DATA_WIDTH +: REG_DATA_WIDTH] =
                    regs_q[read_sel[r*REG_SEL_BITS +: REG_SEL_BITS]];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NUM_WRITE; w++) begin
                        if (wEn[w] && (write_sel[w*REG_SEL_BITS +: REG_SEL_BITS] ==
                                       read_sel[r*REG_SEL_BITS +: REG_SEL_BITS])) begin
                            read_data[r*REG_DATA_WIDTH +: REG_DATA_WIDTH] =
                                write_data[w*REG_DATA_WIDTH +: REG_DATA_WIDTH];
                        end
                    end
                end
            end
        end
    end

    assign ready = ready_q;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Multi-port, parametrised integer register file for the BRISC-V pipelines, replacing the fixed 2-read/1-write file. It provides `NUM_READ` combinational read ports and `NUM_WRITE` write ports. Optional same-cycle write-to-read bypass is selected by `BYPASS`. A hardware clear sequencer zeroes every entry after reset, so no register holds X at boot.

## Interface
- `REG_DATA_WIDTH`, default 32: data width of each entry.
- `REG_SEL_BITS`, default 5: address width; depth is 2^`REG_SEL_BITS`.
- `NUM_READ`, default 2: number of read ports, legal range 1–4.
- `NUM_WRITE`, default 2: number of write ports, legal range 1–2.
- `BYPASS`, default 1: 1 forwards same-cycle write data to matching reads; 0 returns the stored value.

Ports (flat buses; port *i* occupies slice *i*):
- `clock`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ready`  out  1  high when the clear sequence is done and the file is accepting writes.
- `wEn`  in  `NUM_WRITE`  per-port write enable.
- `write_sel`  in  `NUM_WRITE*REG_SEL_BITS`  per-port write address.
- `write_data`  in  `NUM_WRITE*REG_DATA_WIDTH`  per-port write data.
- `read_sel`  in  `NUM_READ*REG_SEL_BITS`  per-port read address.
- `read_data`  out  `NUM_READ*REG_DATA_WIDTH`  per-port read data.

## Operation
- State machine has two states, CLEAR and RUN.
  - `reset`=1 at an edge: state ← CLEAR, clear counter ← 0. This applies from any state, including partway through a clear.
  - In CLEAR, each edge writes entry[counter] ← 0 and then counter ← counter+1.
  - When counter = 2^`REG_SEL_BITS`−1, that entry is written and state ← RUN.
  - RUN is held until the next reset.
- `ready` = (state == RUN). Its reset value is 0.
- In CLEAR:
  - all `wEn` are ignored;
  - all `read_data` are forced to 0.
- Writes in RUN:
  - For port *w*, if `wEn[w]`=1 and `write_sel[w]`≠0, the entry is written at the edge.
  - Writes to address 0 are dropped.
- Write conflict: if both ports are enabled to the same non-zero address, port 1 wins and port 0's data is discarded.
- Reads in RUN are combinational.
  - `read_sel`=0 always returns 0, regardless of bypass.
  - With `BYPASS`=1, when `read_sel[r]` matches an enabled, non-zero `write_sel[w]` in the same cycle, `read_data[r]` = `write_data[w]`.
  - When both write ports match, port 1's data is returned, consistent with the conflict rule.
  - With `BYPASS`=0, or with no match, the stored value is returned.
- Read ports are fully independent. Any number of them may address the same entry.
- Widths: the counter is `REG_SEL_BITS`+1 bits or is compared against all-ones. It must not wrap back to 0 inside CLEAR.

## Timing
- Clear latency is 2^`REG_SEL_BITS` cycles (32 at default). `ready` rises after the 32nd edge following the last edge with `reset`=1.
- Write latency: data is stored at the edge where `wEn` is sampled and is visible on the stored path from the next cycle.
- Bypass latency is zero cycles: purely combinational from `write_*` to `read_data`.
- Read latency is zero cycles: combinational from `read_sel` and array contents.
- `reset` asserted in RUN:
  - `ready` drops on that edge;
  - any write presented on that edge is discarded;
  - the full clear restarts.
- `reset` held high for multiple cycles: the counter stays at 0 and `ready` stays 0.

## Test plan
- **Reset clear:** preload entry 7 = 0xDEADBEEF, pulse `reset` for 1 cycle.
  - `ready`=0 for exactly 32 cycles, then 1.
  - All 32 entries then read 0.
  - `wEn` driven during CLEAR has no effect.
- **Dual write:** in RUN, write port 0 x3 = 0x11, port 1 x9 = 0x22 in one cycle.
  - Next cycle `read_sel`={3,9} returns {0x11, 0x22}.
- **Conflict:** both ports write x5 with 0xAAAA and 0x5555.
  - x5 reads 0x5555 afterwards.
  - With `BYPASS`=1, the same-cycle read of x5 also returns 0x5555.
- **Bypass:** x4 holds 0x1; write x4 = 0x2 while reading x4.
  - `BYPASS`=1: same-cycle read returns 0x2.
  - `BYPASS`=0: same-cycle read returns 0x1.
  - Both configurations return 0x2 on the next cycle.
- **x0:** write x0 = 0xFFFF on both ports with bypass enabled. x0 reads 0 in the same cycle and the next.
- **Reset mid-clear:** assert `reset` at clear count 10. The counter restarts and `ready` rises 32 cycles after the new reset, not 22.
